// File: rtl/branch_ex_if.sv
// Issue-side and result-side bus of the branch execution unit.
// slave: the branch unit itself; master: the issue/consumer side driving it.
interface branch_ex_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned OP_W   = 5,
    parameter int unsigned TAG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_op;
    logic [DATA_W-1:0] in_opO;
    logic [DATA_W-1:0] in_opT;
    logic [DATA_W-1:0] in_imm;
    logic [ADDR_W-1:0] in_pc;
    logic [TAG_W-1:0]  in_tag;
    logic              in_pred_taken;

    logic              out_valid;
    logic              out_ready;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              br_mispredict;
    logic              wb_en;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_data;

    modport slave (
        input  in_valid, in_op, in_opO, in_opT, in_imm, in_pc, in_tag, in_pred_taken,
        input  out_ready,
        output in_ready,
        output out_valid, br_taken, br_target, br_mispredict, wb_en, wb_tag, wb_data
    );

    modport master (
        output in_valid, in_op, in_opO, in_opT, in_imm, in_pc, in_tag, in_pred_taken,
        output out_ready,
        input  in_ready,
        input  out_valid, br_taken, br_target, br_mispredict, wb_en, wb_tag, wb_data
    );
endinterface

// File: rtl/branch_ex.sv
// Branch execution unit: two-stage (registered issue -> result register) branch
// resolver producing the PC redirect and the JAL/JALR link write for the CDB.
// Optional macro BRANCH_STAT_EN adds saturating branch/mispredict counters.
module branch_ex #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned OP_W   = 5,
    parameter int unsigned TAG_W  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    branch_ex_if.slave  bus
`ifdef BRANCH_STAT_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);
    typedef enum logic [OP_W-1:0] {
        OP_NOP  = OP_W'(0),
        OP_JAL  = OP_W'(1),
        OP_JALR = OP_W'(2),
        OP_BEQ  = OP_W'(3),
        OP_BNE  = OP_W'(4),
        OP_BLT  = OP_W'(5),
        OP_BGE  = OP_W'(6),
        OP_BLTU = OP_W'(7),
        OP_BGEU = OP_W'(8)
    } op_e;

    // stage 1: registered issue
    logic              s1_valid;
    logic [OP_W-1:0]   s1_op;
    logic [DATA_W-1:0] s1_opo;
    logic [DATA_W-1:0] s1_opt;
    logic [DATA_W-1:0] s1_imm;
    logic [ADDR_W-1:0] s1_pc;
    logic [TAG_W-1:0]  s1_tag;
    logic              s1_pred;

    // stage 2: result register
    logic              s2_valid;
    logic              s2_taken;
    logic [ADDR_W-1:0] s2_target;
    logic              s2_mispredict;
    logic              s2_link;
    logic [TAG_W-1:0]  s2_tag;
    logic [DATA_W-1:0] s2_data;

    logic              s1_advance;
    logic              in_ready;
    logic              out_xfer;

    // resolve results from stage 1
    logic              r_taken;
    logic              r_is_br;
    logic              r_link;
    logic              r_jalr;
    logic [ADDR_W-1:0] r_pc_imm;
    logic [ADDR_W-1:0] r_pc4;
    logic [DATA_W-1:0] r_jalr_sum;
    logic [ADDR_W-1:0] r_jalr_tgt;
    logic [ADDR_W-1:0] r_target;

    assign s1_advance = !s2_valid || bus.out_ready;
    assign in_ready   = !s1_valid || s1_advance;
    assign out_xfer   = s2_valid && bus.out_ready;

    assign r_pc_imm   = s1_pc + ADDR_W'(s1_imm);
    assign r_pc4      = s1_pc + ADDR_W'(4);
    assign r_jalr_sum = (s1_opo + s1_imm) & ~DATA_W'(1);
    assign r_jalr_tgt = ADDR_W'(r_jalr_sum);

    // decode opcode and resolve direction; unknown opcodes act as NOP
    always_comb begin
        r_taken = 1'b0;
        r_is_br = 1'b1;
        r_link  = 1'b0;
        r_jalr  = 1'b0;
        case (s1_op)
            OP_JAL:  begin r_taken = 1'b1; r_link = 1'b1; end
            OP_JALR: begin r_taken = 1'b1; r_link = 1'b1; r_jalr = 1'b1; end
            OP_BEQ:  r_taken = (s1_opo == s1_opt);
            OP_BNE:  r_taken = (s1_opo != s1_opt);
            OP_BLT:  r_taken = ($signed(s1_opo) <  $signed(s1_opt));
            OP_BGE:  r_taken = ($signed(s1_opo) >= $signed(s1_opt));
            OP_BLTU: r_taken = (s1_opo <  s1_opt);
            OP_BGEU: r_taken = (s1_opo >= s1_opt);
            default: r_is_br = 1'b0;
        endcase
        r_target = r_taken ? (r_jalr ? r_jalr_tgt : r_pc_imm) : r_pc4;
    end

    // pipeline registers: reset, then flush, then normal advance/refill
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_op         <= '0;
            s1_opo        <= '0;
            s1_opt        <= '0;
            s1_imm        <= '0;
            s1_pc         <= '0;
            s1_tag        <= '0;
            s1_pred       <= 1'b0;
            s2_valid      <= 1'b0;
            s2_taken      <= 1'b0;
            s2_target     <= '0;
            s2_mispredict <= 1'b0;
            s2_link       <= 1'b0;
            s2_tag        <= '0;
            s2_data       <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_advance) begin
                s2_valid <= s1_valid && r_is_br;
                if (s1_valid && r_is_br) begin
                    s2_taken      <= r_taken;
                    s2_target     <= r_target;
                    s2_mispredict <= r_taken != s1_pred;
                    s2_link       <= r_link;
                    s2_tag        <= s1_tag;
                    s2_data       <= DATA_W'(r_pc4);
                end
            end
            if (in_ready) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_op   <= bus.in_op;
                    s1_opo  <= bus.in_opO;
                    s1_opt  <= bus.in_opT;
                    s1_imm  <= bus.in_imm;
                    s1_pc   <= bus.in_pc;
                    s1_tag  <= bus.in_tag;
                    s1_pred <= bus.in_pred_taken;
                end
            end
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = s2_valid;
    assign bus.br_taken      = s2_taken;
    assign bus.br_target     = s2_target;
    assign bus.br_mispredict = s2_mispredict;
    assign bus.wb_tag        = s2_tag;
    assign bus.wb_data       = s2_data;
    assign bus.wb_en         = out_xfer && s2_link && (s2_tag != '0);

`ifdef BRANCH_STAT_EN
    // saturating transfer counters; survive flush, cleared only by rst
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (out_xfer) begin
            if (stat_branches != '1)
                stat_branches <= stat_branches + 32'd1;
            if (s2_mispredict && stat_mispredicts != '1)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif
endmodule
